fb_scanout: RTL and testbench
=============================

FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 clk  in  1  system clock, 50 MHz; all state updates on its rising edge.
REQ-002 resetn  in  1  reset, asynchronous and active-low; one clock, no other clock domains.
REQ-003 mem_addr  out  17  framebuffer read address, row-major, addr = y*320 + x, range 0..76799.
REQ-004 mem_rdata  in  3  colour {R,G,B} from synchronous framebuffer RAM; valid one clk edge after mem_addr.
REQ-005 VGA_CLK  out  1  pixel clock, 25 MHz, equal to the internal pix_en phase.
REQ-006 VGA_HS  out  1  horizontal sync, active-low.
REQ-007 VGA_VS  out  1  vertical sync, active-low.
REQ-008 VGA_BLANK_N  out  1  high only during the visible region.
REQ-009 VGA_SYNC_N  out  1  constant 1.
REQ-010 VGA_R, VGA_G, VGA_B  out  10 each  each channel is its colour bit replicated 10 times; all 0 when blanked.
REQ-011 frame_start  out  1  one-clk pulse when the counters wrap to (h=0, v=0).
REQ-012 vblank  out  1  high while v >= 480; lets the sprite-draw FSM write without tearing.

Function
REQ-013 pix_en shall toggle every clk; counters h and v shall advance only on edges where pix_en=1.
REQ-014 h shall count 0..799 and then wrap to 0.
REQ-015 v shall increment only when h wraps, counting 0..524 and then wrapping to 0.
REQ-016 The visible region shall be h<640 && v<480.
REQ-017 Horizontal sync shall be low for h in 656..751 inclusive.
REQ-018 Vertical sync shall be low for v in 490..491 inclusive.
REQ-019 Framebuffer coordinates shall be x=h[9:1], y=v[9:1], giving 2x2 pixel replication of 320x240 onto 640x480.
REQ-020 Row base shall be a register holding y*320, maintained incrementally with no multiplier:
- +320 when v increments and v[0]=1 before the increment;
- cleared to 0 when v wraps.
REQ-021 mem_addr shall equal row_base + x, combinational from registered state.
REQ-022 mem_addr shall be held at the last visible address (or 0) outside the visible region; the value there is don't-care to the RAM, but it shall never exceed 76799.
REQ-023 On each pix_en=1 edge, these shall register together from the pre-advance counter state:
- VGA_HS, VGA_VS, VGA_BLANK_N;
- colour = mem_rdata gated by visible.
Sync and colour therefore stay aligned with one-pixel output latency.
REQ-024 mem_rdata for the address presented at pix_en=1 edge k shall be captured at edge k+2 clk (the next pix_en=1 edge).
REQ-025 frame_start shall assert for exactly one clk, on the clk after the edge where h=799 and v=524 advance to (0,0).
REQ-026 vblank shall be combinational from the v register.
REQ-027 Wrap of h and v on the same edge shall be a single event: v→0, row_base→0, frame_start pulse.
REQ-028 No input handshake: scanout free-runs continuously after reset release; framebuffer writes from the draw datapath do not stall it.

Reset
REQ-029 While resetn=0 the following shall hold, asynchronously:
- h=0, v=0, pix_en=0, row_base=0, mem_addr=0;
- VGA_CLK=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0;
- VGA_R/G/B=0, frame_start=0.
REQ-030 Reset asserted mid-line or mid-frame shall abort immediately. After release, the first pix_en=1 edge occurs on the 2nd clk, and scanout restarts at (h=0, v=0) with no partial pulse on frame_start.

Verification
REQ-031 Release reset, run 2 frames:
- exactly 800*525*2 = 840000 clks per frame;
- frame_start pulses 2 times, spaced 840000 clks apart.
REQ-032 Sync timing within a line and frame:
- VGA_HS low for 96 pixels (192 clks), starting 16 pixels after blank begins;
- VGA_VS low for exactly 2 lines (3200 clks) starting at line 490;
- VGA_BLANK_N high for 640 pixels per line on lines 0..479.
REQ-033 Address sequence with a RAM model returning addr[2:0]:
- mem_addr sequence on line v=0: 0,0,1,1,...,319,319;
- line v=2 starts at 320; line v=479 ends at 76799;
- VGA_R/G/B match the model one pixel later.
REQ-034 Blank gating: RAM model returns 3'b111 constantly → RGB all-ones only while BLANK_N=1, all 0 during h>=640 or v>=480.
REQ-035 Reset at h=700, v=300 for 3 clks:
- outputs take reset values within the same cycle;
- after release, counters restart at (0,0) and the next frame_start occurs 840000 clks later.
REQ-036 vblank rises at the start of line 480 and falls when v wraps to 0, coincident with frame_start.

Source files
------------

// File: rtl/fb_scanout_if.sv
// Framebuffer scanout bundle: framebuffer read port plus the VGA DAC pins
// and the frame-timing flags consumed by the drawing side.
interface fb_scanout_if;
    logic [16:0] mem_addr;
    logic [2:0]  mem_rdata;
    logic        VGA_CLK;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK_N;
    logic        VGA_SYNC_N;
    logic [9:0]  VGA_R;
    logic [9:0]  VGA_G;
    logic [9:0]  VGA_B;
    logic        frame_start;
    logic        vblank;

    // Scanout engine side: drives the address and all video outputs.
    modport master (
        output mem_addr,
        input  mem_rdata,
        output VGA_CLK,
        output VGA_HS,
        output VGA_VS,
        output VGA_BLANK_N,
        output VGA_SYNC_N,
        output VGA_R,
        output VGA_G,
        output VGA_B,
        output frame_start,
        output vblank
    );

    // Framebuffer / display side: returns colour, observes the video pins.
    modport slave (
        input  mem_addr,
        output mem_rdata,
        input  VGA_CLK,
        input  VGA_HS,
        input  VGA_VS,
        input  VGA_BLANK_N,
        input  VGA_SYNC_N,
        input  VGA_R,
        input  VGA_G,
        input  VGA_B,
        input  frame_start,
        input  vblank
    );
endinterface

// File: rtl/fb_scanout.sv
// 640x480@60 VGA scanout of a 320x240 3-bit framebuffer with 2x2 pixel
// replication. Runs from a 50 MHz clock with a divide-by-two pixel enable;
// free-running after reset, no handshake. The framebuffer RAM is synchronous
// with one cycle of read latency, which the pixel-enable phase hides: the
// address settles after a pixel edge, the RAM samples it on the following
// off-phase edge, and the colour is captured on the next pixel edge.
// The timing parameters default to the standard 640x480 mode; the row stride
// of the framebuffer is half the visible line width.
module fb_scanout #(
    parameter int H_VISIBLE    = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_END   = 751,
    parameter int H_TOTAL      = 800,
    parameter int V_VISIBLE    = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_END   = 491,
    parameter int V_TOTAL      = 525
) (
    input  logic          clk,
    input  logic          resetn,
    fb_scanout_if.master  vga
);

    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_VIS     = 10'(H_VISIBLE);
    localparam logic [9:0]  V_VIS     = 10'(V_VISIBLE);
    localparam logic [9:0]  HS_FIRST  = 10'(H_SYNC_START);
    localparam logic [9:0]  HS_LAST   = 10'(H_SYNC_END);
    localparam logic [9:0]  VS_FIRST  = 10'(V_SYNC_START);
    localparam logic [9:0]  VS_LAST   = 10'(V_SYNC_END);
    localparam logic [16:0] FB_STRIDE = 17'(H_VISIBLE / 2);

    // Timing state
    logic        pix_en;
    logic [9:0]  h;
    logic [9:0]  v;
    logic [16:0] row_base;

    // Registered video outputs
    logic        hs_q;
    logic        vs_q;
    logic        blank_n_q;
    logic [2:0]  colour_q;
    logic        frame_start_q;

    // Decodes of the current (pre-advance) counter state
    logic        h_wrap;
    logic        v_wrap;
    logic        visible;
    logic        hsync_active;
    logic        vsync_active;
    logic [8:0]  fb_x;

    // Counter decodes used by every register below.
    always_comb begin
        h_wrap       = (h == H_LAST);
        v_wrap       = (v == V_LAST);
        visible      = (h < H_VIS) && (v < V_VIS);
        hsync_active = (h >= HS_FIRST) && (h <= HS_LAST);
        vsync_active = (v >= VS_FIRST) && (v <= VS_LAST);
        fb_x         = h[9:1];
    end

    // Pixel enable: toggles every clock, giving the 25 MHz pixel phase.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pix_en <= 1'b0;
        end else begin
            pix_en <= ~pix_en;
        end
    end

    // Horizontal and vertical counters; a joint wrap is one event to (0,0).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h <= '0;
            v <= '0;
        end else if (pix_en) begin
            if (h_wrap) begin
                h <= '0;
                if (v_wrap) begin
                    v <= '0;
                end else begin
                    v <= v + 10'd1;
                end
            end else begin
                h <= h + 10'd1;
            end
        end
    end

    // Row base = y*stride kept incrementally: bump when leaving an odd line
    // (y = v/2 changes), clear on frame wrap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            row_base <= '0;
        end else if (pix_en && h_wrap) begin
            if (v_wrap) begin
                row_base <= '0;
            end else if (v[0]) begin
                row_base <= row_base + FB_STRIDE;
            end
        end
    end

    // Sync, blank and colour register together from the same counter state
    // so they stay aligned with one pixel of output latency.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            colour_q  <= 3'b000;
        end else if (pix_en) begin
            hs_q      <= ~hsync_active;
            vs_q      <= ~vsync_active;
            blank_n_q <= visible;
            colour_q  <= visible ? vga.mem_rdata : 3'b000;
        end
    end

    // One-clock pulse on the clock after the counters wrap to (0,0).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= pix_en && h_wrap && v_wrap;
        end
    end

    // Framebuffer address and output pins; the address parks at 0 while
    // blanked so it never leaves the framebuffer.
    always_comb begin
        vga.mem_addr    = visible ? (row_base + {8'd0, fb_x}) : 17'd0;
        vga.VGA_CLK     = pix_en;
        vga.VGA_HS      = hs_q;
        vga.VGA_VS      = vs_q;
        vga.VGA_BLANK_N = blank_n_q;
        vga.VGA_SYNC_N  = 1'b1;
        vga.VGA_R       = {10{colour_q[2]}};
        vga.VGA_G       = {10{colour_q[1]}};
        vga.VGA_B       = {10{colour_q[0]}};
        vga.frame_start = frame_start_q;
        vga.vblank      = (v >= V_VIS);
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: a full-size instance for line-level timing, address
// sequence, colour alignment, blank gating and mid-line reset, and a
// reduced-timing instance that reaches the frame-level events (vsync,
// vblank, frame_start, row-base clear) within a short run.
module tb_fb_scanout;

    typedef struct {
        int          n;
        logic [16:0] addr;
        logic        vga_clk;
        logic        hs;
        logic        vs;
        logic        blank_n;
        logic [2:0]  rgb;
        logic        vblank;
        logic        fs;
    } vec_t;

    logic clk = 1'b0;
    logic resetn_a;
    logic resetn_b;
    logic ram_const;

    int checks;
    int failures;

    vec_t vec_a[$];
    vec_t vec_b[$];

    // clock / reset block
    always #10 clk = ~clk;

    fb_scanout_if if_a ();
    fb_scanout_if if_b ();

    fb_scanout dut_a (
        .clk    (clk),
        .resetn (resetn_a),
        .vga    (if_a.master)
    );

    fb_scanout #(
        .H_VISIBLE    (8),
        .H_SYNC_START (10),
        .H_SYNC_END   (13),
        .H_TOTAL      (16),
        .V_VISIBLE    (6),
        .V_SYNC_START (7),
        .V_SYNC_END   (8),
        .V_TOTAL      (10)
    ) dut_b (
        .clk    (clk),
        .resetn (resetn_b),
        .vga    (if_b.master)
    );

    // Synchronous RAM models: colour = addr[2:0], or constant white.
    always @(posedge clk) begin
        if_a.mem_rdata <= ram_const ? 3'b111 : if_a.mem_addr[2:0];
        if_b.mem_rdata <= if_b.mem_addr[2:0];
    end

    task automatic check(input string name, input int nn,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s n=%0d got=%0h want=%0h", name, nn, act, exp);
        end
    endtask

    task automatic cmp_vec(input string tag, input vec_t e,
                           input logic [16:0] addr, input logic vclk,
                           input logic hs, input logic vs, input logic bn,
                           input logic [29:0] rgb, input logic vb,
                           input logic fs, input logic sync_n);
        logic [29:0] exp_rgb;
        exp_rgb = {{10{e.rgb[2]}}, {10{e.rgb[1]}}, {10{e.rgb[0]}}};
        check({tag, "_addr"},    e.n, 32'(addr), 32'(e.addr));
        check({tag, "_vga_clk"}, e.n, 32'(vclk), 32'(e.vga_clk));
        check({tag, "_hs"},      e.n, 32'(hs),   32'(e.hs));
        check({tag, "_vs"},      e.n, 32'(vs),   32'(e.vs));
        check({tag, "_blank_n"}, e.n, 32'(bn),   32'(e.blank_n));
        check({tag, "_rgb"},     e.n, 32'(rgb),  32'(exp_rgb));
        check({tag, "_vblank"},  e.n, 32'(vb),   32'(e.vblank));
        check({tag, "_fs"},      e.n, 32'(fs),   32'(e.fs));
        check({tag, "_sync_n"},  e.n, 32'(sync_n), 32'd1);
    endtask

    task automatic vecs_a(input int n, input int max_n);
        foreach (vec_a[i]) begin
            if (vec_a[i].n == n && n <= max_n) begin
                cmp_vec("a", vec_a[i], if_a.mem_addr, if_a.VGA_CLK, if_a.VGA_HS,
                        if_a.VGA_VS, if_a.VGA_BLANK_N,
                        {if_a.VGA_R, if_a.VGA_G, if_a.VGA_B},
                        if_a.vblank, if_a.frame_start, if_a.VGA_SYNC_N);
            end
        end
    endtask

    task automatic vecs_b(input int n);
        foreach (vec_b[i]) begin
            if (vec_b[i].n == n) begin
                cmp_vec("b", vec_b[i], if_b.mem_addr, if_b.VGA_CLK, if_b.VGA_HS,
                        if_b.VGA_VS, if_b.VGA_BLANK_N,
                        {if_b.VGA_R, if_b.VGA_G, if_b.VGA_B},
                        if_b.vblank, if_b.frame_start, if_b.VGA_SYNC_N);
            end
        end
    endtask

    task automatic reset_values_a(input string tag, input int nn);
        check({tag, "_addr"},    nn, 32'(if_a.mem_addr), 32'd0);
        check({tag, "_vga_clk"}, nn, 32'(if_a.VGA_CLK), 32'd0);
        check({tag, "_hs"},      nn, 32'(if_a.VGA_HS), 32'd1);
        check({tag, "_vs"},      nn, 32'(if_a.VGA_VS), 32'd1);
        check({tag, "_blank_n"}, nn, 32'(if_a.VGA_BLANK_N), 32'd0);
        check({tag, "_rgb"},     nn, 32'({if_a.VGA_R, if_a.VGA_G, if_a.VGA_B}), 32'd0);
        check({tag, "_fs"},      nn, 32'(if_a.frame_start), 32'd0);
        check({tag, "_vblank"},  nn, 32'(if_a.vblank), 32'd0);
    endtask

    int fs_count;
    int fs_first;
    int fs_second;
    int vs_low;
    int vb_high;
    int hs_low;
    int bn_high;
    int max_addr;

    initial begin
        checks    = 0;
        failures  = 0;
        resetn_a  = 1'b0;
        resetn_b  = 1'b0;
        ram_const = 1'b0;

        // Full-size instance: {n, addr, vga_clk, hs, vs, blank_n, rgb, vblank, fs}
        vec_a.push_back('{1,    17'd0,   1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0});
        vec_a.push_back('{2,    17'd0,   1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0});
        vec_a.push_back('{4,    17'd1,   1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0});
        vec_a.push_back('{6,    17'd1,   1'b0, 1'b1, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0});
        vec_a.push_back('{14,   17'd3,   1'b0, 1'b1, 1'b1, 1'b1, 3'b011, 1'b0, 1'b0});
        vec_a.push_back('{15,   17'd3,   1'b1, 1'b1, 1'b1, 1'b1, 3'b011, 1'b0, 1'b0});
        vec_a.push_back('{1280, 17'd0,   1'b0, 1'b1, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0});
        vec_a.push_back('{1282, 17'd0,   1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0});
        vec_a.push_back('{1312, 17'd0,   1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0});
        vec_a.push_back('{1314, 17'd0,   1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0});
        vec_a.push_back('{1504, 17'd0,   1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0});
        vec_a.push_back('{1506, 17'd0,   1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0});
        vec_a.push_back('{1600, 17'd0,   1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0});
        vec_a.push_back('{1602, 17'd0,   1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0});
        vec_a.push_back('{3200, 17'd320, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0});
        vec_a.push_back('{3202, 17'd320, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0});
        vec_a.push_back('{3206, 17'd321, 1'b0, 1'b1, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0});
        vec_a.push_back('{4820, 17'd325, 1'b0, 1'b1, 1'b1, 1'b1, 3'b100, 1'b0, 1'b0});
        vec_a.push_back('{6400, 17'd640, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0});
        vec_a.push_back('{6402, 17'd640, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0});
        vec_a.push_back('{6414, 17'd643, 1'b0, 1'b1, 1'b1, 1'b1, 3'b011, 1'b0, 1'b0});

        // Reduced instance (16x10 timing, 4x3 framebuffer)
        vec_b.push_back('{64,  17'd4,  1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0});
        vec_b.push_back('{174, 17'd11, 1'b0, 1'b1, 1'b1, 1'b1, 3'b011, 1'b0, 1'b0});
        vec_b.push_back('{182, 17'd0,  1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0});
        vec_b.push_back('{191, 17'd0,  1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0});
        vec_b.push_back('{192, 17'd0,  1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0});
        vec_b.push_back('{224, 17'd0,  1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0});
        vec_b.push_back('{226, 17'd0,  1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0});
        vec_b.push_back('{289, 17'd0,  1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0});
        vec_b.push_back('{290, 17'd0,  1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0});
        vec_b.push_back('{319, 17'd0,  1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0});
        vec_b.push_back('{320, 17'd0,  1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1});
        vec_b.push_back('{321, 17'd0,  1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0});
        vec_b.push_back('{324, 17'd1,  1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0});
        vec_b.push_back('{326, 17'd1,  1'b0, 1'b1, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0});
        vec_b.push_back('{384, 17'd4,  1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0});
        vec_b.push_back('{640, 17'd0,  1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1});

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_values_a("reset", 0);

        // Reduced instance: two frames plus a margin
        fs_count = 0; fs_first = -1; fs_second = -1;
        vs_low = 0; vb_high = 0; max_addr = 0;
        resetn_b = 1'b1;
        for (int n = 1; n <= 700; n++) begin
            @(posedge clk);
            @(negedge clk);
            vecs_b(n);
            if (if_b.frame_start === 1'b1) begin
                fs_count++;
                if (fs_first < 0) fs_first = n;
                else if (fs_second < 0) fs_second = n;
            end
            if (n <= 320 && if_b.VGA_VS === 1'b0) vs_low++;
            if (n <= 320 && if_b.vblank === 1'b1) vb_high++;
            if (int'(if_b.mem_addr) > max_addr) max_addr = int'(if_b.mem_addr);
        end
        check("b_fs_count",   700, fs_count, 2);
        check("b_fs_first",   700, fs_first, 320);
        check("b_fs_spacing", 700, fs_second - fs_first, 320);
        check("b_vs_low_clks", 320, vs_low, 64);
        check("b_vblank_clks", 320, vb_high, 128);
        check("b_max_addr",   700, max_addr, 11);

        // Full-size instance: first five lines and into the sixth
        fs_count = 0; vs_low = 0; hs_low = 0; bn_high = 0;
        resetn_a = 1'b1;
        for (int n = 1; n <= 7801; n++) begin
            int p;
            @(posedge clk);
            @(negedge clk);
            vecs_a(n, 7801);
            p = n / 2;
            if (n >= 2 && n <= 1599)
                check("line0_addr", n, 32'(if_a.mem_addr), (p < 640) ? (p >> 1) : 0);
            if (n >= 1602 && n <= 3201) begin
                if (if_a.VGA_HS === 1'b0) hs_low++;
                if (if_a.VGA_BLANK_N === 1'b1) bn_high++;
            end
            if (if_a.frame_start === 1'b1) fs_count++;
            if (if_a.VGA_VS === 1'b0) vs_low++;
        end
        check("a_hs_low_clks", 3201, hs_low, 192);
        check("a_blank_clks",  3201, bn_high, 1280);
        check("a_no_fs",       7801, fs_count, 0);
        check("a_no_vs",       7801, vs_low, 0);

        // Mid-line reset at h=700 (hsync low, pixel clock high)
        check("pre_reset_hs",  7801, 32'(if_a.VGA_HS), 32'd0);
        check("pre_reset_clk", 7801, 32'(if_a.VGA_CLK), 32'd1);
        #2 resetn_a = 1'b0;
        #1 reset_values_a("async_reset", 7801);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_values_a("held_reset", 0);
        resetn_a = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            vecs_a(n, 20);
            check("restart_no_fs", n, 32'(if_a.frame_start), 32'd0);
        end

        // Blank gating with a constant-white framebuffer
        resetn_a  = 1'b0;
        ram_const = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resetn_a = 1'b1;
        for (int n = 1; n <= 3201; n++) begin
            int q;
            logic vis;
            @(posedge clk);
            @(negedge clk);
            if (n >= 2) begin
                q   = n / 2 - 1;
                vis = ((q % 800) < 640) && ((q / 800) < 480);
                check("gate_rgb", n, 32'({if_a.VGA_R, if_a.VGA_G, if_a.VGA_B}),
                      vis ? 32'h3FFF_FFFF : 32'd0);
                check("gate_blank_n", n, 32'(if_a.VGA_BLANK_N), 32'(vis));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
